// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and constants for the byte-RAM word arbiter.
package ram_arb_pkg;
    localparam int RAM_AW  = 10;
    localparam int BEATS   = 4;
    localparam int WORD_AW = RAM_AW - 2;
    localparam int BEAT_W  = 2;
    typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant with pointer register.
// RAM_ARB_FIXED_PRIO_EN reduces it to fixed priority (requester 0 wins).
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       upd,
    input  logic       last,
    output logic       gnt
);
`ifdef RAM_ARB_FIXED_PRIO_EN
    logic unused;
    assign unused = &{1'b0, clk, rst, upd, last, req[1]};
    assign gnt = !req[0];
`else
    logic ptr;
    always_ff @(posedge clk) begin
        if (rst) ptr <= 1'b0;
        else if (upd) ptr <= ~last;
    end
    // ptr selects the favoured requester; fall back to the other one
    assign gnt = ptr ? req[1] : !req[0];
`endif
endmodule

// File: rtl/ram_word_arbiter.sv
// ram_word_arbiter: shares a byte-wide RAM between two word requesters, four beats per word.
// Define RAM_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module ram_word_arbiter
    import ram_arb_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               r0_req,
    input  logic               r0_we,
    input  logic [WORD_AW-1:0] r0_addr,
    input  logic [31:0]        r0_wdata,
    input  logic [3:0]         r0_be,
    output logic               r0_ack,
    output logic [31:0]        r0_rdata,
    input  logic               r1_req,
    input  logic               r1_we,
    input  logic [WORD_AW-1:0] r1_addr,
    input  logic [31:0]        r1_wdata,
    input  logic [3:0]         r1_be,
    output logic               r1_ack,
    output logic [31:0]        r1_rdata,
    output logic [RAM_AW-1:0]  ram_addr,
    output logic [7:0]         ram_d,
    output logic               ram_we,
    input  logic [7:0]         ram_q
);
    if (BEATS != 4) begin : g_beats_check
        $error("ram_word_arbiter supports exactly 4 beats per word");
    end

    state_t             state;
    logic [BEAT_W-1:0]  beat;
    logic               id;
    logic               we_q;
    logic [WORD_AW-1:0] addr_q;
    logic [31:0]        wdata_q;
    logic [3:0]         be_q;
    logic [23:0]        rbuf;
    logic               gnt;

    rr_arb2 u_arb (
        .clk  (clk),
        .rst  (rst),
        .req  ({r1_req, r0_req}),
        .upd  (state == RESP),
        .last (id),
        .gnt  (gnt)
    );

    assign ram_addr = {addr_q, beat};
    assign ram_d    = 8'(wdata_q >> {beat, 3'b000});
    // rst gates the strobe so the beat in flight when reset arrives is not written
    assign ram_we   = (state == XFER) && we_q && be_q[beat] && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            beat     <= '0;
            id       <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            rbuf     <= '0;
            r0_ack   <= 1'b0;
            r1_ack   <= 1'b0;
            r0_rdata <= '0;
            r1_rdata <= '0;
        end else begin
            case (state)
                IDLE: if (r0_req || r1_req) begin
                    id      <= gnt;
                    we_q    <= gnt ? r1_we : r0_we;
                    addr_q  <= gnt ? r1_addr : r0_addr;
                    wdata_q <= gnt ? r1_wdata : r0_wdata;
                    be_q    <= gnt ? r1_be : r0_be;
                    beat    <= '0;
                    state   <= XFER;
                end
                XFER: begin
                    beat <= beat + 1'b1;
                    // bytes shift in from the top so beat 0 ends up in the low byte
                    rbuf <= {ram_q, rbuf[23:8]};
                    if (beat == BEAT_W'(BEATS - 1)) begin
                        state  <= RESP;
                        r0_ack <= !id;
                        r1_ack <= id;
                        if (!we_q && !id) r0_rdata <= {ram_q, rbuf};
                        if (!we_q && id) r1_rdata <= {ram_q, rbuf};
                    end
                end
                default: begin
                    r0_ack <= 1'b0;
                    r1_ack <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule
